regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Issue-gating scoreboard for the 32-entry integer register file read ports.
//  - Tracks which rd indices have an in-flight write.
//  - Stalls the decode stage on RAW (rs1/rs2 busy) or WAW (rd busy) hazards.
//  - Clears busy bits on writeback and flush.
//  - Sits between operand register decode (supplies indices) and the issue/execute stage.
// PARAMETERS
//  MAX_INFLIGHT  4  max outstanding register writes (1..31); issue stalls when reached
//  WB_BYPASS     1  1: a same-cycle writeback releases the hazard on that index
// PORTS
//  clk             in   1   core clock
//  rst_n           in   1   async active-low reset
//  issue_valid     in   1   decode presents an instruction
//  issue_ready     out  1   scoreboard accepts it (comb); issue fires when valid&&ready
//  rs1_index       in   5   source 1 index (instruction[19:15])
//  rs2_index       in   5   source 2 index (instruction[24:20])
//  rd_index        in   5   dest index (instruction[11:7])
//  uses_rs1        in   1   instruction reads rs1
//  uses_rs2        in   1   instruction reads rs2
//  writes_rd       in   1   instruction writes rd
//  wb_valid        in   1   writeback of one register this cycle
//  wb_rd_index     in   5   index being written back
//  flush           in   1   pipeline flush: drop all in-flight writes
//  busy_mask       out  32  registered busy bits, bit0 always 0
//  inflight_count  out  $clog2(MAX_INFLIGHT+1)  registered outstanding-write count
//  stall_cycles    out  32  registered count of cycles with issue_valid && !issue_ready
// BEHAVIOUR
//  Reset (async on rst_n low):
//   - busy_mask=0, inflight_count=0, stall_cycles=0.
//   - issue_ready follows the combinational rule below; it is 1 after reset with no hazards.
//  Index 0:
//   - Never busy; a source or dest of x0 never causes a hazard.
//   - writes_rd with rd_index=0 does not set a bit and does not count as in flight.
//  Effective busy (eff) = busy_mask, minus bit wb_rd_index when wb_valid && WB_BYPASS.
//  issue_ready = !flush && !(uses_rs1 && eff[rs1]) && !(uses_rs2 && eff[rs2])
//                && !(writes_rd && rd!=0 && eff[rd])
//                && !(writes_rd && rd!=0 && inflight_count==MAX_INFLIGHT && !wb_valid)
//  Next state, evaluated in priority order:
//   1. flush: busy_mask<=0, inflight_count<=0; any concurrent issue or wb is ignored.
//   2. wb_valid with busy[wb_rd_index]: clear the bit and decrement the count.
//      wb_valid to a non-busy index or to x0 is ignored; no underflow.
//   3. Issue fire with writes_rd && rd!=0: set busy[rd] and increment the count.
//      - Same-cycle wb to the same rd (WB_BYPASS=1): the bit ends up 1 and the count is unchanged.
//  Latency:
//   - A set bit is visible in busy_mask the cycle after the issue fire.
//   - A back-to-back dependent instruction stalls until its writeback cycle, with WB_BYPASS=1,
//     or until the cycle after it, with WB_BYPASS=0.
//  Counters:
//   - inflight_count always equals popcount(busy_mask).
//   - stall_cycles saturates at 32'hFFFF_FFFF and does not increment during flush.
//  Handshake: issue_valid may drop without firing; nothing is latched unless valid&&ready.
//  Reset mid-operation: all state is cleared immediately; in-flight writebacks arriving after reset are ignored.
// STRUCTURE
//  Shared package core_pkg:
//   - typedef logic [4:0] reg_idx_t;
//   - localparam REG_COUNT=32;
//   - localparam REG_ZERO=5'd0.
//  Sub-module scoreboard_hazard_check (combinational):
//   - Computes issue_ready from eff, the indices and the use flags.
//   - The parent holds the busy/count/stall registers.
// TESTING
//  - Reset: rst_n=0 then 1 -> busy_mask=0, inflight_count=0, issue_ready=1 with issue_valid=1, no uses.
//  - RAW: issue rd=5 -> next cycle rs1=5 uses_rs1 gives ready=0. wb_valid rd=5 -> ready=1 that cycle
//    (WB_BYPASS=1), or the next cycle (WB_BYPASS=0).
//  - WAW plus simultaneous wb/issue: busy x7, issue rd=7 while wb rd=7 -> fires; busy[7]=1, count stays 1.
//  - Capacity: issue rd=1..4 with MAX_INFLIGHT=4 -> count=4; rd=6 stalls. Same cycle, wb rd=2 -> fires; count=4.
//  - x0 and flush: issue rd=0 -> mask unchanged. busy x3,x9 then flush=1 with issue_valid -> ready=0, mask=0, count=0.
//  - Stall counter: hold a RAW hazard for 10 cycles -> stall_cycles=10. Async rst_n mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared register-file types and constants for the integer core.
package core_pkg;

   typedef logic [4:0] reg_idx_t;

   localparam int       REG_COUNT = 32;
   localparam reg_idx_t REG_ZERO  = 5'd0;

endpackage

// File: rtl/scoreboard_hazard_check.sv
// Combinational issue gate: RAW/WAW hazards against the effective busy set,
// plus capacity and flush blocking.
module scoreboard_hazard_check
   import core_pkg::*;
(
   input  logic [REG_COUNT-1:0] eff_busy,
   input  reg_idx_t             rs1_index,
   input  reg_idx_t             rs2_index,
   input  reg_idx_t             rd_index,
   input  logic                 uses_rs1,
   input  logic                 uses_rs2,
   input  logic                 writes_rd,
   input  logic                 flush,
   input  logic                 at_capacity,
   output logic                 issue_ready
);

   logic raw1, raw2, waw, cap, rd_live;

   // eff_busy[0] is never set, so x0 sources fall out without a special case
   assign rd_live     = writes_rd && (rd_index != REG_ZERO);
   assign raw1        = uses_rs1 && eff_busy[rs1_index];
   assign raw2        = uses_rs2 && eff_busy[rs2_index];
   assign waw         = rd_live && eff_busy[rd_index];
   assign cap         = rd_live && at_capacity;
   assign issue_ready = !flush && !raw1 && !raw2 && !waw && !cap;

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-gating scoreboard: tracks in-flight rd writes, stalls decode on
// RAW/WAW/capacity hazards, clears on writeback and flush.
module regfile_scoreboard
   import core_pkg::*;
#(
   parameter int MAX_INFLIGHT = 4,
   parameter int WB_BYPASS    = 1,
   localparam int CW          = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 issue_valid,
   output logic                 issue_ready,
   input  reg_idx_t             rs1_index,
   input  reg_idx_t             rs2_index,
   input  reg_idx_t             rd_index,
   input  logic                 uses_rs1,
   input  logic                 uses_rs2,
   input  logic                 writes_rd,
   input  logic                 wb_valid,
   input  reg_idx_t             wb_rd_index,
   input  logic                 flush,
   output logic [REG_COUNT-1:0] busy_mask,
   output logic [CW-1:0]        inflight_count,
   output logic [31:0]          stall_cycles
);

   logic [REG_COUNT-1:0] eff_busy, nxt_mask;
   logic [CW-1:0]        nxt_cnt;
   logic                 at_capacity, fire, wb_clr, set_rd, stall_inc;

   // a same-cycle writeback hides its index from the hazard check
   always_comb begin
      eff_busy = busy_mask;
      if (wb_valid && (WB_BYPASS != 0)) eff_busy[wb_rd_index] = 1'b0;
   end

   assign at_capacity = (inflight_count == CW'(MAX_INFLIGHT)) && !wb_valid;

   scoreboard_hazard_check u_hazard (
      .eff_busy    (eff_busy),
      .rs1_index   (rs1_index),
      .rs2_index   (rs2_index),
      .rd_index    (rd_index),
      .uses_rs1    (uses_rs1),
      .uses_rs2    (uses_rs2),
      .writes_rd   (writes_rd),
      .flush       (flush),
      .at_capacity (at_capacity),
      .issue_ready (issue_ready)
   );

   assign fire      = issue_valid && issue_ready;
   assign wb_clr    = wb_valid && (wb_rd_index != REG_ZERO) && busy_mask[wb_rd_index];
   assign set_rd    = fire && writes_rd && (rd_index != REG_ZERO);
   assign stall_inc = issue_valid && !issue_ready && !flush && (stall_cycles != 32'hFFFF_FFFF);

   // clear before set so a same-index wb+issue leaves the bit set, count unchanged
   always_comb begin
      nxt_mask = busy_mask;
      nxt_cnt  = inflight_count;
      if (flush) begin
         nxt_mask = '0;
         nxt_cnt  = '0;
      end else begin
         if (wb_clr) begin
            nxt_mask[wb_rd_index] = 1'b0;
            nxt_cnt               = nxt_cnt - CW'(1);
         end
         if (set_rd) begin
            nxt_mask[rd_index] = 1'b1;
            nxt_cnt            = nxt_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_mask      <= '0;
         inflight_count <= '0;
         stall_cycles   <= '0;
      end else begin
         busy_mask      <= nxt_mask;
         inflight_count <= nxt_cnt;
         if (stall_inc) stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard (MAX_INFLIGHT=4, WB_BYPASS=1).
module tb_regfile_scoreboard;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_ready;
   reg_idx_t    rs1_index, rs2_index, rd_index, wb_rd_index;
   logic        uses_rs1, uses_rs2, writes_rd, wb_valid, flush;
   logic [31:0] busy_mask;
   logic [2:0]  inflight_count;
   logic [31:0] stall_cycles;

   typedef struct {
      string       name;
      logic        rdy;
      logic [31:0] mask;
      logic [2:0]  cnt;
      logic        chk_st;
      logic [31:0] st;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   logic done   = 1'b0;

   regfile_scoreboard #(.MAX_INFLIGHT(4), .WB_BYPASS(1)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .rs1_index      (rs1_index),
      .rs2_index      (rs2_index),
      .rd_index       (rd_index),
      .uses_rs1       (uses_rs1),
      .uses_rs2       (uses_rs2),
      .writes_rd      (writes_rd),
      .wb_valid       (wb_valid),
      .wb_rd_index    (wb_rd_index),
      .flush          (flush),
      .busy_mask      (busy_mask),
      .inflight_count (inflight_count),
      .stall_cycles   (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input reg_idx_t r1, input reg_idx_t r2, input reg_idx_t rd,
                        input logic u1, input logic u2, input logic wr,
                        input logic wbv, input reg_idx_t wbi, input logic fl);
      issue_valid = iv; rs1_index = r1; rs2_index = r2; rd_index = rd;
      uses_rs1 = u1; uses_rs2 = u2; writes_rd = wr;
      wb_valid = wbv; wb_rd_index = wbi; flush = fl;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic expect_out(input string nm, input logic rdy, input logic [31:0] m,
                             input logic [2:0] c, input logic cs, input logic [31:0] s);
      exp_t e;
      e.name = nm; e.rdy = rdy; e.mask = m; e.cnt = c; e.chk_st = cs; e.st = s;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   // monitor: compares each pending expectation against the DUT mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) break;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".ready"}, {31'd0, issue_ready}, {31'd0, e.rdy});
            chk({e.name, ".busy_mask"}, busy_mask, e.mask);
            chk({e.name, ".inflight"}, {29'd0, inflight_count}, {29'd0, e.cnt});
            if (e.chk_st) chk({e.name, ".stall_cycles"}, stall_cycles, e.st);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d expectations unchecked, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] m;
      rst_n = 1'b0;
      idle();
      cyc(); cyc();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      expect_out("reset", 1'b1, 32'h0, 3'd0, 1'b1, 32'd0);
      cyc();
      rst_n = 1'b1;

      // RAW on x5 with writeback bypass
      drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      expect_out("raw_issue", 1'b1, 32'h0, 3'd0, 1'b1, 32'd0); cyc();
      drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      expect_out("raw_stall", 1'b0, 32'h20, 3'd1, 1'b1, 32'd0); cyc();
      drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
      expect_out("raw_wb_bypass", 1'b1, 32'h20, 3'd1, 1'b1, 32'd1); cyc();
      idle();
      expect_out("raw_clear", 1'b1, 32'h0, 3'd0, 1'b1, 32'd1); cyc();

      // WAW on x7, then same-cycle wb+issue
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      expect_out("waw_first", 1'b1, 32'h0, 3'd0, 1'b1, 32'd1); cyc();
      expect_out("waw_stall", 1'b0, 32'h80, 3'd1, 1'b1, 32'd1); cyc();
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
      expect_out("waw_wb_issue", 1'b1, 32'h80, 3'd1, 1'b1, 32'd2); cyc();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
      expect_out("waw_keep", 1'b1, 32'h80, 3'd1, 1'b1, 32'd2); cyc();
      idle();
      expect_out("wb_clear", 1'b1, 32'h0, 3'd0, 1'b1, 32'd2); cyc();

      // capacity: fill x1..x4, x6 blocked until a writeback frees a slot
      m = 32'h0;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 5'd0, 5'd0, 5'(i), 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
         expect_out("cap_fill", 1'b1, m, 3'(i - 1), 1'b1, 32'd2); cyc();
         m = m | (32'd1 << i);
      end
      drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      expect_out("cap_full_stall", 1'b0, 32'h1E, 3'd4, 1'b1, 32'd2); cyc();
      drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
      expect_out("cap_wb_fire", 1'b1, 32'h1E, 3'd4, 1'b1, 32'd3); cyc();
      idle();
      expect_out("cap_after", 1'b1, 32'h5A, 3'd4, 1'b1, 32'd3); cyc();

      // flush clears everything and blocks issue; not counted as a stall
      drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
      expect_out("flush_cap", 1'b0, 32'h5A, 3'd4, 1'b1, 32'd3); cyc();
      drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      expect_out("flush_done", 1'b1, 32'h0, 3'd0, 1'b1, 32'd3); cyc();
      drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      expect_out("busy_x3", 1'b1, 32'h8, 3'd1, 1'b1, 32'd3); cyc();
      drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
      expect_out("flush_ready", 1'b0, 32'h208, 3'd2, 1'b1, 32'd3); cyc();

      // x0 never busy; wb to a non-busy index does not underflow
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
      expect_out("x0_issue", 1'b1, 32'h0, 3'd0, 1'b1, 32'd3); cyc();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0);
      expect_out("x0_mask", 1'b1, 32'h0, 3'd0, 1'b1, 32'd3); cyc();
      idle();
      expect_out("wb_nonbusy", 1'b1, 32'h0, 3'd0, 1'b1, 32'd3); cyc();

      // stall counter over 10 RAW cycles, then async reset mid-cycle
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      expect_out("st_issue", 1'b1, 32'h0, 3'd0, 1'b1, 32'd0); cyc();
      drive(1'b1, 5'd0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         expect_out("st_stall", 1'b0, 32'h100, 3'd1, 1'b1, 32'(k)); cyc();
      end
      expect_out("st_ten", 1'b0, 32'h100, 3'd1, 1'b1, 32'd10);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      cyc();
      expect_out("rst_mid", 1'b1, 32'h0, 3'd0, 1'b1, 32'd0); cyc();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
      expect_out("late_wb", 1'b1, 32'h0, 3'd0, 1'b1, 32'd0); cyc();
      idle();
      expect_out("late_wb_after", 1'b1, 32'h0, 3'd0, 1'b1, 32'd0); cyc();
      cyc();
      done = 1'b1;
   end

endmodule
